// File: rtl/key_extract_mt.sv
`default_nettype none
// ============================================================================
// Module   : key_extract_mt
// Multi-tenant match-key extractor with a 2-stage valid/ready pipeline.
// Optional feature macro KEY_MASK_EN adds a per-tenant key mask.
// Revision : 1.0
// ============================================================================
module key_extract_mt #(
   parameter int STAGE_ID = 0,
   parameter int PHV_LEN  = 1124,
   parameter int KEY_LEN  = 197,
   parameter int KEY_OFF  = 18,
   parameter int TBL_AW   = 4,
   parameter int TID_MSB  = 140
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [PHV_LEN-1:0]         phv_in,
   input  logic                       phv_valid_in,
   output logic                       phv_ready_out,
   input  logic                       ready_in,
   input  logic                       cfg_wr_en,
   input  logic [TBL_AW-1:0]          cfg_wr_addr,
`ifdef KEY_MASK_EN
   input  logic [KEY_OFF+KEY_LEN-1:0] cfg_wr_data,
`else
   input  logic [KEY_OFF-1:0]         cfg_wr_data,
`endif
   output logic [PHV_LEN-1:0]         phv_out,
   output logic                       phv_valid_out,
   output logic [KEY_LEN-1:0]         key_out,
   output logic                       key_valid_out,
`ifdef KEY_MASK_EN
   output logic [KEY_LEN-1:0]         key_mask_out,
`endif
   output logic [31:0]                pkt_cnt_out
);

   localparam int c_depth   = 2**TBL_AW;
   localparam int c_c6_base = PHV_LEN - 8*48;
   localparam int c_c4_base = c_c6_base - 8*32;
   localparam int c_c2_base = c_c4_base - 8*16;
   localparam int c_op_msb  = 355 - 20*STAGE_ID;
   localparam int c_cmp_bit = 4 - STAGE_ID;

   logic               r_v1, r_v2;
   logic               w_adv1, w_adv2, w_accept;
   logic [31:0]        r_pkt_cnt;
   logic [KEY_OFF-1:0] r_tbl_off [c_depth];
   logic [PHV_LEN-1:0] r_phv1, r_phv2;
   logic [KEY_OFF-1:0] r_off1;
   logic [7:0]         r_a1, r_b1;
   logic [KEY_LEN-1:0] r_key2;
   logic [7:0]         w_opa, w_opb;
   logic [17:0]        w_op_in;
   logic [1:0]         w_cmp_sel;
   logic               w_cmp_res;
   logic [4:0]         w_cmp;
   logic [KEY_LEN-1:0] w_key;
   logic [7:0]         w_in6 [8];
   logic [7:0]         w_in4 [8];
   logic [7:0]         w_in2 [8];
   logic [47:0]        w_k6  [8];
   logic [31:0]        w_k4  [8];
   logic [15:0]        w_k2  [8];

   // A stage advances when its register is empty or the next stage drains it.
   assign w_adv2        = ~r_v2 | ready_in;
   assign w_adv1        = ~r_v1 | w_adv2;
   assign w_accept      = phv_valid_in & w_adv1;
   assign phv_ready_out = w_adv1;

`ifdef KEY_MASK_EN
   logic [KEY_LEN-1:0] r_tbl_mask [c_depth];
   logic [KEY_LEN-1:0] r_mask1, r_mask2;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < c_depth; i++) r_tbl_mask[i] <= '0;
         r_mask1 <= '0;
         r_mask2 <= '0;
      end else begin
         if (cfg_wr_en) r_tbl_mask[cfg_wr_addr] <= cfg_wr_data[KEY_LEN-1:0];
         if (w_accept) r_mask1 <= r_tbl_mask[phv_in[TID_MSB -: TBL_AW]];
         if (w_adv2 && r_v1) r_mask2 <= r_mask1;
      end
   end
   assign key_mask_out = r_mask2;
`endif

   // Lookup reads the pre-write entry when a write hits the same address.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < c_depth; i++) r_tbl_off[i] <= '0;
      end else if (cfg_wr_en) begin
`ifdef KEY_MASK_EN
         r_tbl_off[cfg_wr_addr] <= cfg_wr_data[KEY_OFF+KEY_LEN-1 -: KEY_OFF];
`else
         r_tbl_off[cfg_wr_addr] <= cfg_wr_data;
`endif
      end
   end

   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_cont
         assign w_in6[gi] = phv_in[c_c6_base + 48*gi +: 8];
         assign w_in4[gi] = phv_in[c_c4_base + 32*gi +: 8];
         assign w_in2[gi] = phv_in[c_c2_base + 16*gi +: 8];
         assign w_k6[gi]  = r_phv1[c_c6_base + 48*gi +: 48];
         assign w_k4[gi]  = r_phv1[c_c4_base + 32*gi +: 32];
         assign w_k2[gi]  = r_phv1[c_c2_base + 16*gi +: 16];
      end
   endgenerate

   assign w_op_in = phv_in[c_op_msb-2 -: 18];

   always_comb begin
      w_opa = w_op_in[16:9];
      w_opb = w_op_in[7:0];
      if (!w_op_in[17]) begin
         case (w_op_in[13:12])
            2'b10:   w_opa = w_in6[w_op_in[11:9]];
            2'b01:   w_opa = w_in4[w_op_in[11:9]];
            default: w_opa = w_in2[w_op_in[11:9]];
         endcase
      end
      if (!w_op_in[8]) begin
         case (w_op_in[4:3])
            2'b10:   w_opb = w_in6[w_op_in[2:0]];
            2'b01:   w_opb = w_in4[w_op_in[2:0]];
            default: w_opb = w_in2[w_op_in[2:0]];
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v1   <= 1'b0;
         r_phv1 <= '0;
         r_off1 <= '0;
         r_a1   <= '0;
         r_b1   <= '0;
      end else if (w_adv1) begin
         r_v1 <= phv_valid_in;
         if (phv_valid_in) begin
            r_phv1 <= phv_in;
            r_off1 <= r_tbl_off[phv_in[TID_MSB -: TBL_AW]];
            r_a1   <= w_opa;
            r_b1   <= w_opb;
         end
      end
   end

   assign w_cmp_sel = r_phv1[c_op_msb -: 2];

   always_comb begin
      w_cmp_res = 1'b0;
      case (w_cmp_sel)
         2'b00:   w_cmp_res = (r_a1 >  r_b1);
         2'b01:   w_cmp_res = (r_a1 >= r_b1);
         2'b10:   w_cmp_res = (r_a1 == r_b1);
         default: w_cmp_res = 1'b1;
      endcase
      w_cmp            = '0;
      w_cmp[c_cmp_bit] = w_cmp_res;
   end

   assign w_key = {w_k6[r_off1[17:15]], w_k6[r_off1[14:12]],
                   w_k4[r_off1[11:9]],  w_k4[r_off1[8:6]],
                   w_k2[r_off1[5:3]],   w_k2[r_off1[2:0]], w_cmp};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v2   <= 1'b0;
         r_phv2 <= '0;
         r_key2 <= '0;
      end else if (w_adv2) begin
         r_v2 <= r_v1;
         if (r_v1) begin
            r_phv2 <= r_phv1;
`ifdef KEY_MASK_EN
            r_key2 <= w_key & r_mask1;
`else
            r_key2 <= w_key;
`endif
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        r_pkt_cnt <= '0;
      else if (w_accept) r_pkt_cnt <= r_pkt_cnt + 32'd1;
   end

   assign phv_out       = r_phv2;
   assign phv_valid_out = r_v2;
   assign key_out       = r_key2;
   assign key_valid_out = r_v2;
   assign pkt_cnt_out   = r_pkt_cnt;

endmodule
`default_nettype wire
